// File: rtl/adv7393_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adv7393_line_scheduler
// Brief    : Ping-pong line fetch scheduler between the AXI read DMA and the
//            ADV7393 pixel interface. Define ADV7393_SCHED_UNDERRUN_CNT_EN to
//            add the saturating underrun_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module adv7393_line_scheduler #(
    parameter int H_ACTIVE    = 720,
    parameter int V_ACTIVE    = 576,
    parameter int LINE_STRIDE = 1440
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic [31:0] fb_base,
    output logic        dma_cmd_valid,
    input  logic        dma_cmd_ready,
    output logic [31:0] dma_cmd_addr,
    output logic [15:0] dma_cmd_len,
    output logic        dma_cmd_buf,
    input  logic        dma_done,
    output logic        line_ready,
    output logic        rd_sel,
    input  logic        line_consumed,
    output logic        frame_done,
    output logic        underrun,
    input  logic        underrun_clr,
`ifdef ADV7393_SCHED_UNDERRUN_CNT_EN
    output logic [15:0] underrun_cnt,
`endif
    output logic        busy
);

    localparam logic [15:0] c_dma_len = 16'(H_ACTIVE * 2);
    localparam logic [31:0] c_stride  = 32'(LINE_STRIDE);
    localparam int          c_idx_w   = $clog2(V_ACTIVE + 1);
    localparam logic [c_idx_w-1:0] c_v_active = c_idx_w'(V_ACTIVE);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FLUSH     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_t;

    state_t             state_q, state_d;
    buf_state_t         buf_q [2];
    buf_state_t         buf_d [2];
    logic [31:0]        addr_q, addr_d;
    logic [c_idx_w-1:0] line_idx_q, line_idx_d;
    logic               wr_sel_q, wr_sel_d;
    logic               rd_sel_q, rd_sel_d;
    logic               dma_cmd_valid_q, dma_cmd_valid_d;
    logic               line_ready_q, line_ready_d;
    logic               frame_done_q, frame_done_d;
    logic               underrun_q, underrun_d;
    logic               busy_q, busy_d;
    logic               w_accept, w_consume, w_underrun_ev, w_clear, w_go_idle;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        line_idx_d    = line_idx_q;
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        buf_d         = buf_q;
        underrun_d    = underrun_q;
        frame_done_d  = 1'b0;
        w_accept      = dma_cmd_valid_q & dma_cmd_ready;
        w_consume     = line_consumed & line_ready_q;
        w_underrun_ev = line_consumed & ~line_ready_q;
        w_clear       = 1'b0;
        w_go_idle     = 1'b0;

        if (w_consume) begin
            buf_d[rd_sel_q] = BUF_EMPTY;
            rd_sel_d        = ~rd_sel_q;
        end

        if (w_underrun_ev) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (frame_start) begin
                    addr_d  = fb_base;
                    w_clear = 1'b1;
                end
            end
            ST_ISSUE: begin
                // A handshake completes even if enable drops or a restart
                // arrives in the same cycle: the DMA now owns that command.
                if (w_accept) begin
                    buf_d[wr_sel_q] = BUF_FILLING;
                    wr_sel_d        = ~wr_sel_q;
                    addr_d          = addr_q + c_stride;
                    line_idx_d      = line_idx_q + c_idx_w'(1);
                    state_d         = ST_WAIT_DONE;
                    if (enable && frame_start) begin
                        addr_d  = fb_base;
                        state_d = ST_FLUSH;
                    end
                end else if (!enable) begin
                    w_go_idle = 1'b1;
                end else if (frame_start) begin
                    addr_d  = fb_base;
                    w_clear = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (dma_done) begin
                    buf_d[~wr_sel_q] = BUF_FULL;
                    state_d          = ST_ISSUE;
                    if (!enable) begin
                        w_go_idle = 1'b1;
                    end else if (frame_start) begin
                        addr_d  = fb_base;
                        w_clear = 1'b1;
                    end
                end else if (enable && frame_start) begin
                    addr_d  = fb_base;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // New base was latched on entry; later frame_starts are absorbed.
                if (dma_done) begin
                    if (!enable) w_go_idle = 1'b1;
                    else         w_clear   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_clear || w_go_idle) begin
            buf_d[0]   = BUF_EMPTY;
            buf_d[1]   = BUF_EMPTY;
            wr_sel_d   = 1'b0;
            rd_sel_d   = 1'b0;
            line_idx_d = '0;
            state_d    = w_go_idle ? ST_IDLE : ST_ISSUE;
        end

        // Frame end is evaluated on next-state values so frame_done lands
        // one cycle after the final consume.
        if ((state_d == ST_ISSUE) && (line_idx_d == c_v_active) &&
            (buf_d[0] == BUF_EMPTY) && (buf_d[1] == BUF_EMPTY)) begin
            state_d      = ST_ARMED;
            frame_done_d = 1'b1;
        end

        dma_cmd_valid_d = (state_d == ST_ISSUE) && (line_idx_d < c_v_active) &&
                          (buf_d[wr_sel_d] == BUF_EMPTY);
        line_ready_d    = (buf_d[rd_sel_d] == BUF_FULL);
        busy_d          = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            buf_q[0]        <= BUF_EMPTY;
            buf_q[1]        <= BUF_EMPTY;
            addr_q          <= '0;
            line_idx_q      <= '0;
            wr_sel_q        <= 1'b0;
            rd_sel_q        <= 1'b0;
            dma_cmd_valid_q <= 1'b0;
            line_ready_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            underrun_q      <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            buf_q           <= buf_d;
            addr_q          <= addr_d;
            line_idx_q      <= line_idx_d;
            wr_sel_q        <= wr_sel_d;
            rd_sel_q        <= rd_sel_d;
            dma_cmd_valid_q <= dma_cmd_valid_d;
            line_ready_q    <= line_ready_d;
            frame_done_q    <= frame_done_d;
            underrun_q      <= underrun_d;
            busy_q          <= busy_d;
        end
    end

`ifdef ADV7393_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (w_underrun_ev) begin
            if (underrun_clr)        underrun_cnt_d = 16'd1;
            else if (~&underrun_cnt_q) underrun_cnt_d = underrun_cnt_q + 16'd1;
        end else if (underrun_clr) begin
            underrun_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) underrun_cnt_q <= '0;
        else        underrun_cnt_q <= underrun_cnt_d;
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

    assign dma_cmd_valid = dma_cmd_valid_q;
    assign dma_cmd_addr  = addr_q;
    assign dma_cmd_len   = c_dma_len;
    assign dma_cmd_buf   = wr_sel_q;
    assign line_ready    = line_ready_q;
    assign rd_sel        = rd_sel_q;
    assign frame_done    = frame_done_q;
    assign underrun      = underrun_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_adv7393_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adv7393_line_scheduler
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a line-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adv7393_line_scheduler;

    localparam int H_ACTIVE    = 8;
    localparam int V_ACTIVE    = 4;
    localparam int LINE_STRIDE = 32'h100;
    localparam logic c_h = 1'b1;
    localparam logic c_l = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] fb_base = '0;
    logic        dma_cmd_valid;
    logic        dma_cmd_ready = 1'b0;
    logic [31:0] dma_cmd_addr;
    logic [15:0] dma_cmd_len;
    logic        dma_cmd_buf;
    logic        dma_done = 1'b0;
    logic        line_ready;
    logic        rd_sel;
    logic        line_consumed = 1'b0;
    logic        frame_done;
    logic        underrun;
    logic        underrun_clr = 1'b0;
    logic        busy;
    logic [15:0] underrun_cnt;

    always #5 clk = ~clk;

    adv7393_line_scheduler #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .LINE_STRIDE(LINE_STRIDE)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .frame_start  (frame_start),
        .fb_base      (fb_base),
        .dma_cmd_valid(dma_cmd_valid),
        .dma_cmd_ready(dma_cmd_ready),
        .dma_cmd_addr (dma_cmd_addr),
        .dma_cmd_len  (dma_cmd_len),
        .dma_cmd_buf  (dma_cmd_buf),
        .dma_done     (dma_done),
        .line_ready   (line_ready),
        .rd_sel       (rd_sel),
        .line_consumed(line_consumed),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
`ifdef ADV7393_SCHED_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .busy         (busy)
    );

`ifndef ADV7393_SCHED_UNDERRUN_CNT_EN
    assign underrun_cnt = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        fs;
        logic [31:0] fb;
        logic        rdy;
        logic        done;
        logic        cons;
        logic        e_valid;
        logic [31:0] e_addr;
        logic        e_buf;
        logic        e_lr;
        logic        e_rd;
        logic        e_fd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic fs, input logic [31:0] fb, input logic rdy,
                        input logic done, input logic cons, input logic clr);
        frame_start   = fs;
        fb_base       = fb;
        dma_cmd_ready = rdy;
        dma_done      = done;
        line_consumed = cons;
        underrun_clr  = clr;
        tick();
        frame_start   = 1'b0;
        dma_cmd_ready = 1'b0;
        dma_done      = 1'b0;
        line_consumed = 1'b0;
        underrun_clr  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, dma_cmd_valid, 0);
        chk({tag, "_addr"}, dma_cmd_addr, 0);
        chk({tag, "_buf"}, dma_cmd_buf, 0);
        chk({tag, "_len"}, dma_cmd_len, 16);
        chk({tag, "_lr"}, line_ready, 0);
        chk({tag, "_rd"}, rd_sel, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_ur"}, underrun, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef ADV7393_SCHED_UNDERRUN_CNT_EN
        chk({tag, "_cnt"}, underrun_cnt, 0);
`endif
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state for the randomized phase
    bit          m_in_frame, m_out, m_rd, m_ur, m_valid, m_fd;
    int          m_issued, frames;
    logic [31:0] m_base;
    int          m_q [$];
    int          m_cnt;

    initial begin
        // Normal frame: fb_base 0x1000, immediate ready/done, eager consumer
        tbl[0]  = '{c_h, 32'h1000, c_l, c_l, c_l, c_h, 32'h1000, c_l, c_l, c_l, c_l};
        tbl[1]  = '{c_l, 32'h1000, c_h, c_l, c_l, c_l, 32'h0,    c_l, c_l, c_l, c_l};
        tbl[2]  = '{c_l, 32'h1000, c_l, c_h, c_l, c_h, 32'h1100, c_h, c_h, c_l, c_l};
        tbl[3]  = '{c_l, 32'h1000, c_h, c_l, c_h, c_l, 32'h0,    c_l, c_l, c_h, c_l};
        tbl[4]  = '{c_l, 32'h1000, c_l, c_h, c_l, c_h, 32'h1200, c_l, c_h, c_h, c_l};
        tbl[5]  = '{c_l, 32'h1000, c_h, c_l, c_h, c_l, 32'h0,    c_l, c_l, c_l, c_l};
        tbl[6]  = '{c_l, 32'h1000, c_l, c_h, c_l, c_h, 32'h1300, c_h, c_h, c_l, c_l};
        tbl[7]  = '{c_l, 32'h1000, c_h, c_l, c_h, c_l, 32'h0,    c_l, c_l, c_h, c_l};
        tbl[8]  = '{c_l, 32'h1000, c_l, c_h, c_l, c_l, 32'h0,    c_l, c_h, c_h, c_l};
        tbl[9]  = '{c_l, 32'h1000, c_l, c_l, c_h, c_l, 32'h0,    c_l, c_l, c_l, c_h};
        tbl[10] = '{c_l, 32'h1000, c_l, c_l, c_l, c_l, 32'h0,    c_l, c_l, c_l, c_l};

        tick();
        tick();
        chk_reset("rst");

        reset  = 1'b1;
        enable = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("armed_busy", busy, 1);
        chk("armed_valid", dma_cmd_valid, 0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].fs, tbl[i].fb, tbl[i].rdy, tbl[i].done, tbl[i].cons, 1'b0);
            chk($sformatf("tbl%0d_valid", i), dma_cmd_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_addr", i), dma_cmd_addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d_buf", i), dma_cmd_buf, tbl[i].e_buf);
                chk($sformatf("tbl%0d_len", i), dma_cmd_len, 16);
            end
            chk($sformatf("tbl%0d_lr", i), line_ready, tbl[i].e_lr);
            chk($sformatf("tbl%0d_rd", i), rd_sel, tbl[i].e_rd);
            chk($sformatf("tbl%0d_fd", i), frame_done, tbl[i].e_fd);
        end
        chk("tbl_underrun", underrun, 0);

        // Stalled consumer: two lines filled, third command held back
        step(1, 32'h2000, 0, 0, 0, 0);
        step(0, 32'h2000, 1, 0, 0, 0);
        step(0, 32'h2000, 0, 1, 0, 0);
        step(0, 32'h2000, 1, 0, 0, 0);
        step(0, 32'h2000, 0, 1, 0, 0);
        chk("stall_valid0", dma_cmd_valid, 0);
        chk("stall_lr0", line_ready, 1);
        step(0, 32'h2000, 0, 0, 0, 0);
        step(0, 32'h2000, 0, 0, 0, 0);
        chk("stall_valid1", dma_cmd_valid, 0);
        step(0, 32'h2000, 0, 0, 1, 0);
        chk("stall_lr_hold", line_ready, 1);
        chk("stall_rd", rd_sel, 1);
        chk("stall_valid2", dma_cmd_valid, 1);
        chk("stall_addr", dma_cmd_addr, 32'h2200);
        chk("stall_buf", dma_cmd_buf, 0);

        // Restart while a command is outstanding
        step(0, 32'h2000, 1, 0, 0, 0);
        step(1, 32'h3000, 0, 0, 0, 0);
        chk("flush_valid0", dma_cmd_valid, 0);
        step(1, 32'h4000, 0, 0, 0, 0);
        step(0, 32'h4000, 0, 0, 0, 0);
        chk("flush_valid1", dma_cmd_valid, 0);
        step(0, 32'h4000, 0, 1, 0, 0);
        chk("restart_valid", dma_cmd_valid, 1);
        chk("restart_addr", dma_cmd_addr, 32'h3000);
        chk("restart_buf", dma_cmd_buf, 0);
        chk("restart_lr", line_ready, 0);
        chk("restart_rd", rd_sel, 0);

        // Consume with nothing ready
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("ur_set", underrun, 1);
        chk("ur_rd", rd_sel, 0);
        chk("ur_lr", line_ready, 0);
`ifdef ADV7393_SCHED_UNDERRUN_CNT_EN
        chk("ur_cnt1", underrun_cnt, 1);
`endif
        step(0, 0, 0, 1, 0, 0);
        chk("ur_lr_after", line_ready, 1);
        chk("ur_rd_after", rd_sel, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("ur_clr", underrun, 0);
`ifdef ADV7393_SCHED_UNDERRUN_CNT_EN
        chk("ur_cnt0", underrun_cnt, 0);
`endif

        // Address wrap, restart from ISSUE, set-wins on clear
        step(1, 32'hFFFF_FF80, 0, 0, 0, 0);
        chk("wrap_addr0", dma_cmd_addr, 32'hFFFF_FF80);
        chk("wrap_lr", line_ready, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("ur_setwins", underrun, 1);
`ifdef ADV7393_SCHED_UNDERRUN_CNT_EN
        chk("ur_cnt_setwins", underrun_cnt, 1);
`endif
        step(0, 0, 0, 1, 0, 0);
        chk("wrap_valid", dma_cmd_valid, 1);
        chk("wrap_addr1", dma_cmd_addr, 32'h0000_0080);
        chk("wrap_buf", dma_cmd_buf, 1);

        // Reset mid-frame, then frame_start ignored until enable
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        chk_reset("midrst");
        reset  = 1'b1;
        enable = 1'b0;
        step(1, 32'h5000, 0, 0, 0, 0);
        chk("noen_busy", busy, 0);
        chk("noen_valid", dma_cmd_valid, 0);
        enable = 1'b1;
        step(0, 32'h5000, 0, 0, 0, 0);
        chk("en_busy", busy, 1);
        chk("en_valid", dma_cmd_valid, 0);
        step(1, 32'h5000, 0, 0, 0, 0);
        chk("en_start_valid", dma_cmd_valid, 1);
        chk("en_start_addr", dma_cmd_addr, 32'h5000);

        // Randomized traffic against the line-queue model
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        m_in_frame = 0; m_out = 0; m_rd = 0; m_ur = 0; m_valid = 0;
        m_issued = 0; frames = 0; m_base = '0; m_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit fs, rdy, done, cons, clr, lr_prev;
            logic [31:0] fb;
            fs      = !m_in_frame && ($urandom_range(0, 3) == 0);
            fb      = $urandom();
            rdy     = ($urandom_range(0, 1) == 1);
            done    = m_out && ($urandom_range(0, 2) == 0);
            cons    = ($urandom_range(0, 2) == 0);
            clr     = ($urandom_range(0, 9) == 0);
            lr_prev = (m_q.size() > 0);

            if (cons && lr_prev) begin
                void'(m_q.pop_front());
                m_rd = ~m_rd;
            end
            if (cons && !lr_prev)  m_ur = 1;
            else if (clr)          m_ur = 0;
            if (cons && !lr_prev)  m_cnt = clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
            else if (clr)          m_cnt = 0;
            if (fs) begin
                m_in_frame = 1; m_base = fb; m_issued = 0; m_rd = 0;
            end
            if (m_valid && rdy) begin
                m_out = 1;
                m_issued++;
            end
            if (done) begin
                m_out = 0;
                m_q.push_back(m_issued - 1);
            end
            m_fd = m_in_frame && (m_issued == V_ACTIVE) && !m_out && (m_q.size() == 0);
            if (m_fd) begin
                m_in_frame = 0;
                frames++;
            end
            m_valid = m_in_frame && !m_out && (m_issued < V_ACTIVE) && (m_q.size() < 2);

            step(fs, fb, rdy, done, cons, clr);
            chk("rnd_valid", dma_cmd_valid, m_valid);
            if (m_valid) begin
                chk("rnd_addr", dma_cmd_addr, m_base + 32'(m_issued) * 32'(LINE_STRIDE));
                chk("rnd_buf", dma_cmd_buf, 32'(m_issued % 2));
            end
            chk("rnd_lr", line_ready, m_q.size() > 0);
            chk("rnd_rd", rd_sel, m_rd);
            chk("rnd_fd", frame_done, m_fd);
            chk("rnd_ur", underrun, m_ur);
            chk("rnd_busy", busy, 1);
`ifdef ADV7393_SCHED_UNDERRUN_CNT_EN
            chk("rnd_cnt", underrun_cnt, 32'(m_cnt));
`endif
        end
        chk("rnd_frames_seen", frames > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
